// File: rtl/mul_iter.sv
// mul_iter: iterative unsigned W x W -> 2W multiplier for the FPU significand
// datapath. Retires R multiplier bits per cycle, so a product takes W/R BUSY
// cycles. Ready/valid handshakes on both the operand and the product side.
//
// Optional feature: define MUL_ITER_STICKY_EN to drive `sticky` with the OR
// of product[W-1:0], registered with the product. Without the macro the
// sticky port is tied to 0 and the OR-reduction is not built.
//
// W must be a multiple of R (1 <= R <= W).
module mul_iter #(
  parameter int W = 58,
  parameter int R = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   product,
  output logic             sticky
);

  localparam int STEPS = W / R;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  // The multiplicand is held pre-shifted by R*cnt so each step needs only a
  // fixed W x R partial product instead of a variable barrel shift.
  logic [2*W-1:0]   a_q;
  logic [W-1:0]     b_q;
  logic [2*W-1:0]   acc_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   pp;
  logic [2*W-1:0]   acc_d;

`ifdef MUL_ITER_STICKY_EN
  logic             sticky_q;
  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = acc_q;

  // Partial product of the shifted multiplicand with the low R multiplier bits, then accumulate.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // update, otherwise a latch is inferred.
    pp = '0;
    for (int i = 0; i < R; i++) begin
      if (b_q[i]) begin
        pp = pp + (a_q << i);
      end
    end
    acc_d = acc_q + pp;
  end

  // Control FSM and datapath registers; handshake outputs are registered state decodes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the datapath registers are reset too: reset must abort an
      // operation in flight and the product output must read 0 afterwards.
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`ifdef MUL_ITER_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= {{W{1'b0}}, a};
            b_q        <= b;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          a_q   <= a_q << R;
          b_q   <= b_q >> R;
          if (cnt_q == LAST) begin
            // cnt holds at its last value so it never wraps.
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`ifdef MUL_ITER_STICKY_EN
            sticky_q    <= |acc_d[W-1:0];
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef MUL_ITER_STICKY_EN
            sticky_q    <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Testbench for mul_iter: W=58/R=2 main instance with directed and random
// stimulus, plus W=8 instances for R = 1, 2, 4, 8 under random stimulus.
// Each instance has a cycle-level behavioural model (accept -> fixed latency
// -> hold until consumed) compared against the DUT on every falling edge.
module tb_mul_iter;

  localparam int W   = 58;
  localparam int R   = 2;
  localparam int LAT = W / R;

`ifdef MUL_ITER_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  typedef logic [2*W-1:0] prod_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset     = 1'b1;
  logic           sw_reset  = 1'b1;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a         = '0;
  logic [W-1:0]   b         = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  prod_t          product;
  logic           sticky;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  mul_iter #(.W(W), .R(R)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .sticky    (sticky)
  );

  // Behavioural model of the main instance.
  bit    m_idle     = 1'b1;
  bit    m_done     = 1'b0;
  bit    m_rst_seen = 1'b0;
  int    m_left     = 0;
  prod_t m_prod     = '0;

  always @(posedge clk) begin
    m_rst_seen = reset;
    if (reset) begin
      m_idle = 1'b1;
      m_done = 1'b0;
      m_left = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle = 1'b0;
        m_left = LAT;
        m_prod = prod_t'(a) * prod_t'(b);
      end
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
    end else if (out_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_idle);
    check("out_valid", out_valid, m_done);
    if (m_done) begin
      check("product", product, m_prod);
      check("sticky", sticky, STICKY_ON & (|m_prod[W-1:0]));
    end else begin
      check("sticky_not_done", sticky, 1'b0);
    end
    if (m_rst_seen) check("product_after_reset", product, '0);
  end

  function automatic logic [W-1:0] rnd_op();
    return W'({$urandom(), $urandom()});
  endfunction

  function automatic logic [W-1:0] pick_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return rnd_op();
    endcase
  endfunction

  // Present operands for one edge (DUT must be idle), then scramble them.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = rnd_op();
    b        = rnd_op();
  endtask

  // Count edges until out_valid is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handoff();
    @(posedge clk); #1;
  endtask

  // W=8 sweep instances.
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SR   = 1 << g;
    localparam int SLAT = 8 / SR;

    logic        s_in_valid  = 1'b0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic        s_sticky;
    logic [7:0]  s_a = '0;
    logic [7:0]  s_b = '0;
    logic [15:0] s_prod;

    bit          fin    = 1'b0;
    int          ops    = 0;
    bit          m_idle = 1'b1;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [15:0] m_prod = '0;

    mul_iter #(.W(8), .R(SR)) u_dut (
      .clk       (clk),
      .reset     (sw_reset),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .a         (s_a),
      .b         (s_b),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .product   (s_prod),
      .sticky    (s_sticky)
    );

    always @(posedge clk) begin
      if (sw_reset) begin
        m_idle = 1'b1;
        m_done = 1'b0;
        m_left = 0;
      end else if (m_idle) begin
        if (s_in_valid) begin
          m_idle = 1'b0;
          m_left = SLAT;
          m_prod = 16'(s_a) * 16'(s_b);
        end
      end else if (m_left > 0) begin
        m_left--;
        m_done = (m_left == 0);
      end else if (s_out_ready) begin
        m_done = 1'b0;
        m_idle = 1'b1;
        ops++;
      end
    end

    always @(negedge clk) begin
      check($sformatf("sw_r%0d_in_ready", SR), s_in_ready, m_idle);
      check($sformatf("sw_r%0d_out_valid", SR), s_out_valid, m_done);
      if (m_done) begin
        check($sformatf("sw_r%0d_product", SR), s_prod, m_prod);
        check($sformatf("sw_r%0d_sticky", SR), s_sticky, STICKY_ON & (|m_prod[7:0]));
      end
    end

    initial begin
      while (sw_reset) @(negedge clk);
      for (int c = 0; c < 30000 && ops < 1000; c++) begin
        @(negedge clk);
        s_in_valid  = ($urandom_range(0, 4) != 0);
        s_a         = 8'($urandom());
        s_b         = 8'($urandom());
        s_out_ready = ($urandom_range(0, 3) != 0);
      end
      check($sformatf("sw_r%0d_ops_done", SR), ops >= 1000, 1'b1);
      fin = 1'b1;
    end
  end

  initial begin
    int n;
    int extra;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    sw_reset = 1'b0;

    // Basic: 3 * 5.
    start_op(58'd3, 58'd5);
    wait_done(n);
    check("lat_basic", n, 29);
    check("prod_basic", product, 15);
    check("sticky_basic", sticky, STICKY_ON);
    handoff();

    // Maximum operands: (2^58-1)^2 = 2^116 - 2^59 + 1.
    start_op('1, '1);
    wait_done(n);
    check("lat_max", n, 29);
    check("prod_max", product, 116'hF_FFFF_FFFF_FFFF_F800_0000_0000_0001);
    check("sticky_max", sticky, STICKY_ON);
    handoff();

    // 2^57 * 2 = 2^58, low half all zero.
    start_op(58'h200_0000_0000_0000, 58'd2);
    wait_done(n);
    check("prod_pow2", product, 116'h400_0000_0000_0000);
    check("sticky_pow2", sticky, 1'b0);
    handoff();

    // Backpressure: hold the product for 10 cycles.
    out_ready = 1'b0;
    start_op(58'd7, 58'd9);
    wait_done(n);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_prod", product, 63);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", in_ready, 1'b1);
    check("bp_idle_valid", out_valid, 1'b0);
    start_op(58'd2, 58'd3);
    check("bp_accept", in_ready, 1'b0);
    wait_done(n);
    check("bp_prod2", product, 6);
    handoff();

    // Operands presented during BUSY are ignored.
    start_op(58'd11, 58'd13);
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = 58'd99;
    b        = 58'd77;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(n);
    check("lat_ignored", n + 8, 29);
    check("prod_ignored", product, 143);
    handoff();
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check("no_extra_result", extra, 0);

    // Reset at BUSY cycle 10 aborts the operation.
    start_op(58'd5, 58'd6);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_product", product, 0);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check("rst_no_result", extra, 0);

    // Random traffic with occasional resets.
    repeat (3000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) == 0);
      a         = pick_op();
      b         = pick_op();
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 40000; i++) begin
      if (g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin) break;
      @(posedge clk);
    end
    check("sweep_finished",
          g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
